apb_multi_slave_master: RTL and testbench
=========================================

APB_MULTI_SLAVE_MASTER -- requirements
Module: apb_multi_slave_master

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_WIDTH  32  request and PADDR width.
  DATA_WIDTH  32  data width, multiple of 8.
  NUM_SLAVES  4   APB completers, 1..16.
  SEL_LSB     12  lowest PADDR bit of slave index; index = addr[SEL_LSB+3:SEL_LSB].
  TIMEOUT     16  max ACCESS cycles before abort, >=2.
REQ-002 Ports (name, direction, width, meaning), one per line:
  PCLK         in   1                        clock, rising edge.
  PRESET       in   1                        reset, asynchronous, active-high.
  req_valid    in   1                        request present.
  req_ready    out  1                        request accepted when both high.
  req_write    in   1                        1 write, 0 read.
  req_addr     in   ADDR_WIDTH               byte address.
  req_wdata    in   DATA_WIDTH               write data.
  req_strb     in   DATA_WIDTH/8             write byte strobes.
  rsp_valid    out  1                        response present.
  rsp_ready    in   1                        response consumed when both high.
  rsp_rdata    out  DATA_WIDTH               read data, 0 for writes and errors.
  rsp_err      out  1                        PSLVERR, decode error or timeout.
  rsp_timeout  out  1                        error was a timeout.
  PSEL         out  NUM_SLAVES               one-hot completer select.
  PENABLE      out  1                        access phase.
  PWRITE       out  1                        direction.
  PADDR        out  ADDR_WIDTH               address.
  PWDATA       out  DATA_WIDTH               write data.
  PSTRB        out  DATA_WIDTH/8             strobes; all-zero on reads.
  PRDATA       in   NUM_SLAVES*DATA_WIDTH    slave i in bits [i*DATA_WIDTH +: DATA_WIDTH].
  PREADY       in   NUM_SLAVES               per-slave ready.
  PSLVERR      in   NUM_SLAVES               per-slave error.
  err_count    out  8                        saturating error counter.

Function
REQ-003 FSM states: IDLE, SETUP, ACCESS, RESP; one transfer in flight at a time.
REQ-004 IDLE: req_ready=1; on req_valid, capture write, address, wdata and strb, and decode index.
REQ-005 From IDLE: index < NUM_SLAVES -> SETUP; index >= NUM_SLAVES -> RESP with rsp_err=1, rsp_timeout=0, and no PSEL asserted.
REQ-006 SETUP (one cycle): PSEL[index]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from captured values -> ACCESS.
REQ-007 ACCESS: PSEL[index]=1, PENABLE=1; all P* outputs held stable until exit.
REQ-008 ACCESS with PREADY[index]=1: capture PRDATA slice (reads only) and PSLVERR[index] into the response -> RESP; PSEL and PENABLE low next cycle.
REQ-009 Timeout counter: cleared on SETUP entry, incremented each ACCESS cycle with PREADY[index]=0.
REQ-010 Abort on the TIMEOUT-th ACCESS cycle without ready: -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-011 A PREADY in the same cycle as the counter limit is a normal completion, not a timeout.
REQ-012 Only PREADY/PSLVERR/PRDATA of the selected slave are observed; all others are ignored.
REQ-013 RESP: rsp_valid=1 and response fields stable until rsp_ready; on handshake -> IDLE.
REQ-014 Back-to-back throughput: a request can first be accepted the cycle after the RESP handshake.
REQ-015 Minimum latency, accept to rsp_valid: 3 cycles for a zero-wait slave, 1 cycle for a decode error.
REQ-016 err_count increments by 1 on each RESP entry with rsp_err=1 and saturates at 255.
REQ-017 PSEL is never multi-hot; PENABLE=1 only while PSEL != 0.

Reset
REQ-018 PRESET=1 asynchronously forces IDLE; aborts any transfer mid-phase with no response generated.
REQ-019 Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, err_count=0, timeout counter=0.
REQ-020 req_ready is 0 while PRESET=1 and becomes 1 the first cycle after release.

Verification
REQ-021 Write to addr 0x0000_1004, data 0xDEADBEEF, strb 0xF, slave1 zero-wait -> PSEL=0b0010 for setup and access, PWDATA=0xDEADBEEF, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-022 Read 0x0000_3010, slave3 with 2 wait states, PRDATA=0x12345678 -> ACCESS lasts 3 cycles, rsp_rdata=0x12345678, PSTRB=0.
REQ-023 Read 0x0000_5000 with NUM_SLAVES=4 -> no PSEL, rsp_valid 1 cycle after accept, rsp_err=1, rsp_timeout=0, err_count=1.
REQ-024 Slave0 PREADY held low, TIMEOUT=16 -> PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 rsp_ready held low for 5 cycles, then PSLVERR response -> fields stable, req_ready=0 throughout, next request accepted one cycle after handshake.
REQ-026 PRESET asserted during ACCESS -> PSEL, PENABLE and rsp_valid 0 immediately, with no clock edge needed; 300 forced errors -> err_count=255.

Source files
------------

// File: rtl/apb_multi_slave_master.sv
// Purpose: request/response to APB bridge, one transfer in flight, decodes addr[SEL_LSB+3:SEL_LSB] to one of NUM_SLAVES completers.
// Latency: accept to rsp_valid is 3 cycles with a zero-wait completer, 1 cycle on decode error, and at most TIMEOUT+2 cycles otherwise.
// Backpressure: req_ready is low from accept until the response handshake; the response is held until rsp_ready.
//
// Ports:
//   PCLK, PRESET                 clock (rising edge), asynchronous active-high reset
//   req_valid/ready/write/addr/wdata/strb   request channel (valid/ready)
//   rsp_valid/ready/rdata/err/timeout       response channel (valid/ready)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB   APB requester outputs (registered)
//   PRDATA, PREADY, PSLVERR      per-completer APB returns, slave i at slice i
//   err_count                    saturating count of error responses
module apb_multi_slave_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    output logic [7:0]                       err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state;
    logic [TW-1:0]           tcnt;
    logic [3:0]              req_idx;
    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    assign req_idx = req_addr[SEL_LSB+3:SEL_LSB];
    assign dec_hit = ({1'b0, req_idx} < 5'(NUM_SLAVES));

    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec_sel[i] = (req_idx == 4'(i));
        end
    end

    // The registered one-hot PSEL doubles as the return-path mux select, so
    // completers that are not addressed can never influence the response.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            tcnt        <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        PWRITE    <= req_write;
                        PADDR     <= req_addr;
                        PWDATA    <= req_wdata;
                        PSTRB     <= req_write ? req_strb : '0;
                        if (dec_hit) begin
                            PSEL    <= dec_sel;
                            PENABLE <= 1'b0;
                            tcnt    <= '0;
                            state   <= SETUP;
                        end else begin
                            // Unmapped completer: answer directly, APB untouched.
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                            state       <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // Ready is checked before the limit so a completion on the
                    // last allowed cycle is never reported as a timeout.
                    if (sel_ready) begin
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= sel_err;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!PWRITE && !sel_err) ? sel_rdata : '0;
                        if (sel_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
                        state       <= RESP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (tcnt == TW'(TIMEOUT - 1)) begin
                            PSEL        <= '0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Purpose: directed self-checking bench for apb_multi_slave_master.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: rsp_ready and per-completer PREADY are driven explicitly by each directed step.
module tb_apb_multi_slave_master;

    logic         PCLK;
    logic         PRESET;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_strb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_timeout;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;
    logic [7:0]   err_count;

    int tests = 0;
    int fails = 0;

    apb_multi_slave_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .err_count(err_count)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    // Presents one request for a single cycle; caller guarantees req_ready=1.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check(tag, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int acc;
        int nrsp;
        logic stable;

        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b0;
        PRDATA    = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        PREADY    = 4'b1111;
        PSLVERR   = 4'b0000;

        // Reset values
        tick();
        tick();
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        PRESET = 1'b0;
        #1 check("rel_req_ready_low", 64'(req_ready), 64'd0);
        tick();
        check("rel_req_ready_high", 64'(req_ready), 64'd1);

        // Zero-wait write to slave1
        send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        check("wr_setup_psel", 64'(PSEL), 64'h2);
        check("wr_setup_penable", 64'(PENABLE), 64'd0);
        check("wr_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        check("wr_setup_paddr", 64'(PADDR), 64'h1004);
        check("wr_setup_pwrite", 64'(PWRITE), 64'd1);
        check("wr_setup_pstrb", 64'(PSTRB), 64'hF);
        check("wr_req_ready_busy", 64'(req_ready), 64'd0);
        tick();
        check("wr_access_psel", 64'(PSEL), 64'h2);
        check("wr_access_penable", 64'(PENABLE), 64'd1);
        check("wr_access_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_rsp_err", 64'(rsp_err), 64'd0);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_resp_psel", 64'(PSEL), 64'd0);
        check("wr_resp_penable", 64'(PENABLE), 64'd0);
        handshake("wr_hs");
        check("wr_idle_ready", 64'(req_ready), 64'd1);

        // Read slave3, two wait states; other slaves' ready/error set to show they are ignored
        PREADY  = 4'b0111;
        PSLVERR = 4'b0111;
        PRDATA[96 +: 32] = 32'h1234_5678;
        send(1'b0, 32'h0000_3010, 32'h5555_5555, 4'hF);
        check("rd_setup_psel", 64'(PSEL), 64'h8);
        check("rd_setup_pstrb", 64'(PSTRB), 64'd0);
        check("rd_setup_pwrite", 64'(PWRITE), 64'd0);
        tick();
        check("rd_acc1_penable", 64'(PENABLE), 64'd1);
        tick();
        check("rd_acc2_penable", 64'(PENABLE), 64'd1);
        tick();
        check("rd_acc3_penable", 64'(PENABLE), 64'd1);
        check("rd_acc3_psel", 64'(PSEL), 64'h8);
        PREADY[3] = 1'b1;
        tick();
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
        check("rd_rsp_err", 64'(rsp_err), 64'd0);
        handshake("rd_hs");
        PREADY  = 4'b1111;
        PSLVERR = 4'b0000;

        // Decode error: index 5 with four completers
        send(1'b0, 32'h0000_5000, 32'h0, 4'h0);
        check("dec_rsp_valid", 64'(rsp_valid), 64'd1);
        check("dec_psel", 64'(PSEL), 64'd0);
        check("dec_rsp_err", 64'(rsp_err), 64'd1);
        check("dec_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("dec_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("dec_err_count", 64'(err_count), 64'd1);
        handshake("dec_hs");

        // Timeout: slave0 never ready
        PREADY = 4'b1110;
        send(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) break;
            if (PENABLE && PSEL == 4'b0001) acc++;
        end
        check("to_access_cycles", 64'(acc), 64'd16);
        check("to_rsp_valid", 64'(rsp_valid), 64'd1);
        check("to_rsp_err", 64'(rsp_err), 64'd1);
        check("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
        check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("to_psel", 64'(PSEL), 64'd0);
        check("to_err_count", 64'(err_count), 64'd2);
        handshake("to_hs");

        // Ready on the last allowed access cycle completes normally
        PREADY = 4'b1011;
        PRDATA[64 +: 32] = 32'hCAFE_F00D;
        send(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) tick();
        check("lim_still_access", 64'(PENABLE), 64'd1);
        PREADY[2] = 1'b1;
        tick();
        check("lim_rsp_valid", 64'(rsp_valid), 64'd1);
        check("lim_rsp_err", 64'(rsp_err), 64'd0);
        check("lim_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("lim_rsp_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
        check("lim_err_count", 64'(err_count), 64'd2);
        handshake("lim_hs");
        PREADY = 4'b1111;

        // PSLVERR response held under rsp_ready backpressure
        PSLVERR = 4'b0010;
        send(1'b1, 32'h0000_1000, 32'h0000_00FF, 4'h1);
        tick();
        tick();
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rsp_err", 64'(rsp_err), 64'd1);
        check("bp_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("bp_err_count", 64'(err_count), 64'd3);
        PSLVERR = 4'b0000;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(rsp_valid === 1'b1 && rsp_err === 1'b1 && rsp_timeout === 1'b0 &&
                  rsp_rdata === 32'd0 && req_ready === 1'b0)) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0008;
        req_wdata = 32'h0BAD_F00D;
        req_strb  = 4'h3;
        tick();
        rsp_ready = 1'b0;
        check("bp_after_hs_valid", 64'(rsp_valid), 64'd0);
        check("bp_after_hs_ready", 64'(req_ready), 64'd1);
        check("bp_after_hs_psel", 64'(PSEL), 64'd0);
        tick();
        req_valid = 1'b0;
        check("bp_next_psel", 64'(PSEL), 64'h1);
        check("bp_next_pstrb", 64'(PSTRB), 64'h3);
        tick();
        tick();
        check("bp_next_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_next_err_count", 64'(err_count), 64'd3);
        handshake("bp_next_hs");

        // Asynchronous reset in the middle of an access
        PREADY = 4'b1101;
        send(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        tick();
        check("ar_in_access", 64'(PENABLE), 64'd1);
        #1 PRESET = 1'b1;
        #1;
        check("ar_psel", 64'(PSEL), 64'd0);
        check("ar_penable", 64'(PENABLE), 64'd0);
        check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        check("ar_err_count", 64'(err_count), 64'd0);
        tick();
        PRESET = 1'b0;
        PREADY = 4'b1111;
        tick();
        check("ar_req_ready", 64'(req_ready), 64'd1);
        check("ar_no_rsp", 64'(rsp_valid), 64'd0);

        // Saturation: 300 decode errors
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_F000;
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 2000 && nrsp < 300; i++) begin
            tick();
            if (rsp_valid) nrsp++;
            if (nrsp == 255 && rsp_valid) check("sat_at_255", 64'(err_count), 64'd255);
        end
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        check("sat_responses", 64'(nrsp), 64'd300);
        check("sat_err_count", 64'(err_count), 64'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
